// File: rtl/sr_seq_pkg.sv
// Shared types and parameter defaults for the SR latch command sequencer.
package sr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    typedef enum logic {
        CMD_SET = 1'b0,
        CMD_CLR = 1'b1
    } cmd_t;

    localparam int unsigned DEB_CYCLES_DEF   = 4;
    localparam int unsigned PULSE_CYCLES_DEF = 2;

endpackage

// File: rtl/sr_debounce.sv
// Request conditioning: 2-flop synchronizer, stable-count debouncer and a
// one-cycle pulse on each debounced rising edge.
module sr_debounce
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The level flips on the DEB_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], req};
            level_d <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Drives a gated SR latch from debounced set/clear buttons with a
// setup/pulse/hold sequence, then verifies the latch output.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEF,
    parameter bit          SET_PRIORITY = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q,
    output logic s,
    output logic r,
    output logic c,
    output logic busy,
    output logic err
);

    localparam int unsigned PCW = $clog2(PULSE_CYCLES + 1);

    logic           set_rise;
    logic           clr_rise;
    state_t         state, state_next;
    cmd_t           cmd, cmd_next;
    logic [PCW-1:0] pcnt, pcnt_next;
    logic           drive_next;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (set_req),
        .rise  (set_rise)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (clr_req),
        .rise  (clr_rise)
    );

    always_comb begin
        state_next = state;
        cmd_next   = cmd;
        pcnt_next  = pcnt;
        case (state)
            IDLE: begin
                if (set_rise || clr_rise) begin
                    state_next = SETUP;
                    cmd_next   = (set_rise && (SET_PRIORITY || !clr_rise)) ? CMD_SET : CMD_CLR;
                end
            end
            SETUP: begin
                state_next = PULSE;
                pcnt_next  = PCW'(PULSE_CYCLES - 1);
            end
            PULSE: begin
                if (pcnt == '0) state_next = HOLD;
                else            pcnt_next  = pcnt - PCW'(1);
            end
            HOLD:    state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign drive_next = (state_next == SETUP) || (state_next == PULSE) || (state_next == HOLD);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cmd   <= CMD_SET;
            pcnt  <= '0;
            s     <= 1'b0;
            r     <= 1'b0;
            c     <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cmd   <= cmd_next;
            pcnt  <= pcnt_next;
            s     <= drive_next && (cmd_next == CMD_SET);
            r     <= drive_next && (cmd_next == CMD_CLR);
            c     <= (state_next == PULSE);
            busy  <= (state_next != IDLE);
            err   <= (state == HOLD) && (q != (cmd == CMD_SET));
        end
    end

    a_never_sr: assert property (@(posedge clk) disable iff (!rst_n) !(s && r));
    a_c_only_pulse: assert property (@(posedge clk) disable iff (!rst_n) c |-> (state == PULSE));
    a_sr_stable_on_c: assert property (@(posedge clk) disable iff (!rst_n)
        (c || $changed(c)) |-> ($stable(s) && $stable(r)));

endmodule
